// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core slice: opcodes, ALU function codes, FSM states,
// status indicator codes and the NOP/HALT instruction words.
package cpu_pkg;

    localparam logic [5:0] OP_LUI  = 6'b010000;
    localparam logic [5:0] OP_MUL  = 6'b011000;
    localparam logic [5:0] OP_LD   = 6'b100000;
    localparam logic [5:0] OP_ST   = 6'b100001;
    localparam logic [5:0] OP_B    = 6'b101000;
    localparam logic [5:0] OP_BZ   = 6'b101001;
    localparam logic [5:0] OP_BNZ  = 6'b101010;
    localparam logic [5:0] OP_NOP  = 6'b110010;
    localparam logic [5:0] OP_HALT = 6'b110011;

    // Low three opcode bits of both the register and the immediate ALU groups.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_SLT = 3'd7
    } alu_fn_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] IND_HALT  = 2'b00;
    localparam logic [1:0] IND_ERROR = 2'b01;
    localparam logic [1:0] IND_RUN   = 2'b10;

    localparam logic [31:0] NOP_WORD  = 32'hC800_0000;
    localparam logic [31:0] HALT_WORD = 32'hCC00_0000;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for cpu_core: register/immediate ALU operations on a and b.
// Optional: define CPU_MUL_EN to add the MUL operation (low 32 bits of the unsigned product).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic [31:0] w_product;

`ifdef CPU_MUL_EN
    assign w_product = i_a * i_b;
`else
    assign w_product = '0;
`endif

    always_comb begin
        o_result = '0;
        case (alu_fn_t'(i_op[2:0]))
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SHL: o_result = i_a << i_b[4:0];
            ALU_SHR: o_result = i_a >> i_b[4:0];
            ALU_SLT: o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            default: o_result = '0;
        endcase
        if (i_op == OP_MUL) begin
            o_result = w_product;
        end
    end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit load/store core: FETCH/EXEC/MEM/DONE sequencer, 16-entry register file, PC.
// Optional: define CPU_MUL_EN to enable op 011000 (MUL); otherwise it decodes as illegal.
module cpu_core
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    output logic [31:0] instruction_memory_a,
    output logic        instruction_memory_en,
    input  logic [31:0] instruction_memory_v,
    output logic [31:0] data_memory_a,
    output logic        data_memory_read,
    output logic        data_memory_write,
    input  logic [31:0] data_memory_in_v,
    output logic [31:0] data_memory_out_v,
    output logic [1:0]  error_indicator
);

`ifdef CPU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [31:0] r_ir;
    logic [31:0] r_ld_addr;
    logic [1:0]  r_ind, w_ind_next;
    logic [31:0] r_regs [16];

    logic [5:0]  w_op;
    logic [3:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm, w_rs1_val, w_rs2_val, w_rd_val;
    logic [31:0] w_alu_b, w_alu_result, w_mem_addr;
    logic [31:0] w_pc_plus4, w_br_target;
    logic        w_is_alu, w_is_mul;
    logic        w_wb_en;
    logic [31:0] w_wb_data;

    assign w_op  = r_ir[31:26];
    assign w_rd  = r_ir[25:22];
    assign w_rs1 = r_ir[21:18];
    assign w_rs2 = r_ir[17:14];
    assign w_imm = {{16{r_ir[15]}}, r_ir[15:0]};

    // R0 is never written, so reading the array directly yields 0 for it.
    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];
    assign w_rd_val  = r_regs[w_rd];

    assign w_is_alu    = (w_op[5:4] == 2'b00);
    assign w_is_mul    = MUL_EN && (w_op == OP_MUL);
    assign w_alu_b     = w_op[3] ? w_imm : w_rs2_val;
    assign w_mem_addr  = w_rs1_val + w_imm;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {w_imm[29:0], 2'b00};

    assign instruction_memory_a = r_pc;
    assign error_indicator      = r_ind;

    cpu_alu u_alu (
        .i_op     (w_op),
        .i_a      (w_rs1_val),
        .i_b      (w_alu_b),
        .o_result (w_alu_result)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next          = r_state;
        w_pc_next             = r_pc;
        w_ind_next            = r_ind;
        w_wb_en               = 1'b0;
        w_wb_data             = w_alu_result;
        instruction_memory_en = 1'b0;
        data_memory_read      = 1'b0;
        data_memory_write     = 1'b0;
        data_memory_a         = '0;
        data_memory_out_v     = '0;

        unique case (r_state)
            S_FETCH: begin
                instruction_memory_en = clk_en;
                w_state_next          = S_EXEC;
            end
            S_EXEC: begin
                w_state_next = S_FETCH;
                w_pc_next    = w_pc_plus4;
                if (w_is_alu || w_is_mul) begin
                    w_wb_en = 1'b1;
                end else begin
                    case (w_op)
                        OP_LUI: begin
                            w_wb_en   = 1'b1;
                            w_wb_data = {r_ir[15:0], 16'h0000};
                        end
                        OP_LD: begin
                            w_state_next = S_MEM;
                            w_pc_next    = r_pc;
                        end
                        OP_ST: begin
                            data_memory_write = clk_en;
                            data_memory_a     = clk_en ? w_mem_addr : '0;
                            data_memory_out_v = clk_en ? w_rd_val : '0;
                        end
                        OP_B:   w_pc_next = w_br_target;
                        OP_BZ:  if (w_rs1_val == '0) w_pc_next = w_br_target;
                        OP_BNZ: if (w_rs1_val != '0) w_pc_next = w_br_target;
                        OP_NOP: w_pc_next = w_pc_plus4;
                        OP_HALT: begin
                            w_ind_next   = IND_HALT;
                            w_state_next = S_DONE;
                            w_pc_next    = r_pc;
                        end
                        default: begin
                            w_ind_next   = IND_ERROR;
                            w_state_next = S_DONE;
                            w_pc_next    = r_pc;
                        end
                    endcase
                end
            end
            S_MEM: begin
                data_memory_read = clk_en;
                data_memory_a    = clk_en ? r_ld_addr : '0;
                w_wb_en          = 1'b1;
                w_wb_data        = data_memory_in_v;
                w_pc_next        = w_pc_plus4;
                w_state_next     = S_FETCH;
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= NOP_WORD;
            r_ind     <= IND_RUN;
            r_ld_addr <= '0;
        end else if (clk_en) begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ind   <= w_ind_next;
            if (r_state == S_FETCH) begin
                r_ir <= instruction_memory_v;
            end
            if (r_state == S_EXEC) begin
                r_ld_addr <= w_mem_addr;
            end
        end
    end

    // NOTE: the register file is reset on purpose -- software relies on R0..R15 starting at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (clk_en && w_wb_en && (w_rd != 4'd0)) begin
            r_regs[w_rd] <= w_wb_data;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: byte memories on the mid-cycle edge, store scoreboard,
// directed programs (basic, illegal, countdown, load, clock enable, reset mid-load, ALU table, MUL).
module tb_cpu_core;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [31:0] instruction_memory_a;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_v = '0;
    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_in_v = '0;
    logic [31:0] data_memory_out_v;
    logic [1:0]  error_indicator;

    cpu_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .clk_en                (clk_en),
        .instruction_memory_a  (instruction_memory_a),
        .instruction_memory_en (instruction_memory_en),
        .instruction_memory_v  (instruction_memory_v),
        .data_memory_a         (data_memory_a),
        .data_memory_read      (data_memory_read),
        .data_memory_write     (data_memory_write),
        .data_memory_in_v      (data_memory_in_v),
        .data_memory_out_v     (data_memory_out_v),
        .error_indicator       (error_indicator)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    logic [31:0] imem [256];
    logic [7:0]  dmem [4096];
    st_t         sb [$];
    st_t         mon_exp;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_strobe = 0;
    int          n_fetch4 = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, 2'b00, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, rd, rs1, rs2, 14'b0};
    endfunction

    function automatic logic [31:0] rd_word(input int a);
        return {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
    endfunction

    // Memories run at twice the core clock; the mid-cycle edge is the falling core edge.
    always @(negedge clk) begin
        if (instruction_memory_en) instruction_memory_v <= imem[instruction_memory_a[9:2]];
        if (data_memory_read) begin
            data_memory_in_v <= {dmem[data_memory_a[11:0] + 12'd3], dmem[data_memory_a[11:0] + 12'd2],
                                 dmem[data_memory_a[11:0] + 12'd1], dmem[data_memory_a[11:0]]};
        end
        if (data_memory_write) begin
            for (int k = 0; k < 4; k++) dmem[data_memory_a[11:0] + 12'(k)] = data_memory_out_v[8*k +: 8];
            mon_exp = (sb.size() != 0) ? sb.pop_front() : '1;
            check("st_addr", data_memory_a, mon_exp.a);
            check("st_data", data_memory_out_v, mon_exp.d);
        end
        if (instruction_memory_en || data_memory_read || data_memory_write) n_strobe++;
        if (instruction_memory_en && instruction_memory_a == 32'd4) n_fetch4++;
    end

    task automatic begin_test();
        reset  = 1'b1;
        clk_en = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'hFC00_0000;
        for (int i = 0; i < 4096; i++) dmem[i] = 8'h00;
        sb.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to_stop(input int max_cyc, output int cyc);
        cyc = 0;
        while (error_indicator == IND_RUN && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic load_basic();
        imem[0] = 32'h2040_0005;
        imem[1] = 32'h2080_0007;
        imem[2] = 32'h00C4_8000;
        imem[3] = 32'h84C0_0100;
        imem[4] = HALT_WORD;
    endtask

    task automatic load_ld_prog();
        {dmem[16'h203], dmem[16'h202], dmem[16'h201], dmem[16'h200]} = 32'hDEAD_BEEF;
        imem[0] = enc_i(OP_LD, 4'd4, 4'd0, 16'h0200);
        imem[1] = enc_i(OP_ST, 4'd4, 4'd0, 16'h0204);
        imem[2] = HALT_WORD;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] alu_ins [12];
        logic [31:0] alu_exp [12];

        // Basic program, including reset-state checks while reset is held.
        begin_test();
        load_basic();
        sb.push_back('{a: 32'h100, d: 32'h0000_000C});
        #1;
        check("rst_ind", 32'(error_indicator), 32'(IND_RUN));
        check("rst_pc", instruction_memory_a, 32'h0);
        check("rst_rd", 32'(data_memory_read), 32'h0);
        check("rst_wr", 32'(data_memory_write), 32'h0);
        check("rst_dma", data_memory_a, 32'h0);
        check("rst_dout", data_memory_out_v, 32'h0);
        release_reset();
        run_to_stop(100, cyc);
        check("basic_cycles", 32'(cyc), 32'd10);
        check("basic_ind", 32'(error_indicator), 32'(IND_HALT));
        check("basic_mem", rd_word(32'h100), 32'h0000_000C);
        check("basic_pc", instruction_memory_a, 32'd16);
        n_strobe = 0;
        tick(5);
        check("done_strobes", 32'(n_strobe), 32'd0);
        check("done_ind", 32'(error_indicator), 32'(IND_HALT));
        check("basic_sb", 32'(sb.size()), 32'd0);

        // Illegal opcode at address 0.
        begin_test();
        release_reset();
        run_to_stop(100, cyc);
        check("ill_cycles", 32'(cyc), 32'd2);
        check("ill_ind", 32'(error_indicator), 32'(IND_ERROR));
        check("ill_pc", instruction_memory_a, 32'd0);
        n_strobe = 0;
        tick(5);
        check("ill_strobes", 32'(n_strobe), 32'd0);

        // Countdown loop: body at address 4 runs three times; r1 stored to 0x300.
        begin_test();
        imem[0] = enc_i(6'b001000, 4'd1, 4'd0, 16'd3);
        imem[1] = enc_i(6'b001000, 4'd1, 4'd1, 16'hFFFF);
        imem[2] = enc_i(OP_BNZ, 4'd0, 4'd1, 16'hFFFE);
        imem[3] = enc_i(OP_ST, 4'd1, 4'd0, 16'h0300);
        imem[4] = HALT_WORD;
        sb.push_back('{a: 32'h300, d: 32'h0});
        n_fetch4 = 0;
        release_reset();
        run_to_stop(200, cyc);
        check("cnt_cycles", 32'(cyc), 32'd18);
        check("cnt_loops", 32'(n_fetch4), 32'd3);
        check("cnt_ind", 32'(error_indicator), 32'(IND_HALT));
        check("cnt_pc", instruction_memory_a, 32'd16);
        check("cnt_sb", 32'(sb.size()), 32'd0);

        // Load then store the loaded word.
        begin_test();
        load_ld_prog();
        sb.push_back('{a: 32'h204, d: 32'hDEAD_BEEF});
        release_reset();
        run_to_stop(100, cyc);
        check("ld_cycles", 32'(cyc), 32'd7);
        check("ld_ind", 32'(error_indicator), 32'(IND_HALT));
        check("ld_byte0", 32'(dmem[16'h204]), 32'h0000_00EF);
        check("ld_word", rd_word(32'h204), 32'hDEAD_BEEF);
        check("ld_sb", 32'(sb.size()), 32'd0);

        // Clock enable held low for five cycles mid-program.
        begin_test();
        load_basic();
        sb.push_back('{a: 32'h100, d: 32'h0000_000C});
        release_reset();
        tick(5);
        clk_en   = 1'b0;
        n_strobe = 0;
        tick(5);
        check("cen_pc", instruction_memory_a, 32'd8);
        check("cen_ind", 32'(error_indicator), 32'(IND_RUN));
        check("cen_strobes", 32'(n_strobe), 32'd0);
        clk_en = 1'b1;
        run_to_stop(100, cyc);
        check("cen_cycles", 32'(cyc), 32'd5);
        check("cen_ind_end", 32'(error_indicator), 32'(IND_HALT));
        check("cen_mem", rd_word(32'h100), 32'h0000_000C);

        // Reset pulsed while the LD sits in MEM; the program then restarts from PC 0.
        begin_test();
        load_ld_prog();
        release_reset();
        tick(2);
        check("rmem_read", 32'(data_memory_read), 32'd1);
        check("rmem_addr", data_memory_a, 32'h200);
        reset = 1'b1;
        #1;
        check("rmem_ind", 32'(error_indicator), 32'(IND_RUN));
        check("rmem_pc", instruction_memory_a, 32'd0);
        check("rmem_read_off", 32'(data_memory_read), 32'd0);
        check("rmem_nostore", rd_word(32'h204), 32'h0);
        sb.push_back('{a: 32'h204, d: 32'hDEAD_BEEF});
        release_reset();
        run_to_stop(100, cyc);
        check("rmem_cycles", 32'(cyc), 32'd7);
        check("rmem_word", rd_word(32'h204), 32'hDEAD_BEEF);

        // ALU table: r1 = -5, r2 = 3, each result in r3 stored to 0x400 + 4k.
        alu_ins[0]  = enc_r(6'h00, 4'd3, 4'd1, 4'd2); alu_exp[0]  = 32'hFFFF_FFFE;
        alu_ins[1]  = enc_r(6'h01, 4'd3, 4'd1, 4'd2); alu_exp[1]  = 32'hFFFF_FFF8;
        alu_ins[2]  = enc_r(6'h02, 4'd3, 4'd1, 4'd2); alu_exp[2]  = 32'h0000_0003;
        alu_ins[3]  = enc_r(6'h03, 4'd3, 4'd1, 4'd2); alu_exp[3]  = 32'hFFFF_FFFB;
        alu_ins[4]  = enc_r(6'h04, 4'd3, 4'd1, 4'd2); alu_exp[4]  = 32'hFFFF_FFF8;
        alu_ins[5]  = enc_r(6'h05, 4'd3, 4'd1, 4'd2); alu_exp[5]  = 32'hFFFF_FFD8;
        alu_ins[6]  = enc_r(6'h06, 4'd3, 4'd1, 4'd2); alu_exp[6]  = 32'h1FFF_FFFF;
        alu_ins[7]  = enc_r(6'h07, 4'd3, 4'd1, 4'd2); alu_exp[7]  = 32'h0000_0001;
        alu_ins[8]  = enc_i(6'h0A, 4'd3, 4'd1, 16'h00F0); alu_exp[8]  = 32'h0000_00F0;
        alu_ins[9]  = enc_i(6'h0F, 4'd3, 4'd2, 16'hFFFF); alu_exp[9]  = 32'h0000_0000;
        alu_ins[10] = enc_i(6'h0E, 4'd3, 4'd1, 16'd28);   alu_exp[10] = 32'h0000_000F;
        alu_ins[11] = enc_i(OP_LUI, 4'd3, 4'd0, 16'h1234); alu_exp[11] = 32'h1234_0000;
        begin_test();
        imem[0] = enc_i(6'h08, 4'd1, 4'd0, 16'hFFFB);
        imem[1] = enc_i(6'h08, 4'd2, 4'd0, 16'd3);
        for (int k = 0; k < 12; k++) begin
            imem[2 + 2*k] = alu_ins[k];
            imem[3 + 2*k] = enc_i(OP_ST, 4'd3, 4'd0, 16'(32'h400 + 4*k));
            sb.push_back('{a: 32'h400 + 32'(4*k), d: alu_exp[k]});
        end
        imem[26] = HALT_WORD;
        release_reset();
        run_to_stop(200, cyc);
        check("alu_cycles", 32'(cyc), 32'd54);
        check("alu_ind", 32'(error_indicator), 32'(IND_HALT));
        check("alu_sb", 32'(sb.size()), 32'd0);

        // MUL: executes when enabled, otherwise raises ERROR.
        begin_test();
        imem[0] = enc_i(6'h08, 4'd1, 4'd0, 16'hFFFB);
        imem[1] = enc_i(6'h08, 4'd2, 4'd0, 16'd3);
        imem[2] = enc_r(OP_MUL, 4'd3, 4'd1, 4'd2);
        imem[3] = enc_i(OP_ST, 4'd3, 4'd0, 16'h0500);
        imem[4] = HALT_WORD;
`ifdef CPU_MUL_EN
        sb.push_back('{a: 32'h500, d: 32'hFFFF_FFF1});
        release_reset();
        run_to_stop(100, cyc);
        check("mul_cycles", 32'(cyc), 32'd10);
        check("mul_ind", 32'(error_indicator), 32'(IND_HALT));
        check("mul_word", rd_word(32'h500), 32'hFFFF_FFF1);
`else
        release_reset();
        run_to_stop(100, cyc);
        check("mul_cycles", 32'(cyc), 32'd6);
        check("mul_ind", 32'(error_indicator), 32'(IND_ERROR));
        check("mul_pc", instruction_memory_a, 32'd8);
`endif
        check("mul_sb", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Multi-cycle 32-bit load/store CPU with 16 general registers.
- Fetches from a synchronous instruction memory and loads/stores to a synchronous data memory. Both memories are byte-addressed, little-endian, 32-bit wide, and run at 2x the core clock.
- Reports HALT / ERROR / RUNNING status to the system, which stops simulation or hardware on HALT or ERROR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  when 0, all state (PC, IR, regs, FSM) holds; memory strobes are forced to 0.
- instruction_memory_a  out  32  fetch byte address (= PC).
- instruction_memory_en  out  1  fetch strobe.
- instruction_memory_v  in  32  fetched word; valid by the end of the cycle after en/addr are driven.
- data_memory_a  out  32  data byte address.
- data_memory_read  out  1  load strobe.
- data_memory_write  out  1  store strobe.
- data_memory_in_v  in  32  load data; valid by the end of the read cycle.
- data_memory_out_v  out  32  store data.
- error_indicator  out  2  2'b00 = HALT, 2'b01 = ERROR, 2'b10 = RUNNING.

Behaviour:
- Reset (async):
  - PC = RESET_PC, FSM = FETCH, IR = 32'hC800_0000 (NOP).
  - R0–R15 = 0, error_indicator = 2'b10, all strobes 0.
- Encoding:
  - op = [31:26], rd = [25:22], rs1 = [21:18], rs2 = [17:14], imm = [15:0].
  - imm is sign-extended unless stated otherwise.
  - R0 reads as 0; writes to R0 are discarded.
- Register ALU ops, rd = rs1 OP rs2:
  - 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 XOR.
  - 000101 SHL, 000110 SHR (logical); both use shift amount [4:0] of the second operand.
  - 000111 SLT: signed compare, result 1 or 0.
- Immediate ALU ops: 001000–001111 are the same operations with imm replacing rs2.
- 010000 LUI: rd = {imm, 16'h0}.
- 100000 LD: rd = mem32[rs1 + imm].
- 100001 ST: mem32[rs1 + imm] = rd.
- Branches (offsets in words, relative to PC+4):
  - 101000 B: PC = PC + 4 + (imm << 2).
  - 101001 BZ: branch if rs1 == 0.
  - 101010 BNZ: branch if rs1 != 0.
- 110010 NOP (32'hC800_0000). 110011 HALT (32'hCC00_0000).
- Any other op is illegal.
- Arithmetic: all 32-bit, wrap-around, no flags or traps. Data addresses need not be aligned; no alignment error.
- FSM: FETCH, EXEC, MEM, DONE.
- FETCH:
  - Drive instruction_memory_a = PC, instruction_memory_en = 1.
  - Latch IR = instruction_memory_v at end of cycle; go to EXEC.
- EXEC:
  - ALU/LUI: write rd; PC += 4; go to FETCH.
  - Branch: PC = target or PC+4; go to FETCH.
  - ST: data_memory_write = 1, data_memory_a = rs1 + imm, data_memory_out_v = rd, all for exactly this cycle; PC += 4; go to FETCH.
  - LD: latch address; go to MEM.
  - NOP: PC += 4; go to FETCH.
  - HALT: error_indicator = 00; go to DONE.
  - Illegal op: error_indicator = 01; go to DONE.
- MEM: data_memory_read = 1, data_memory_a = latched address; rd = data_memory_in_v at end of cycle; PC += 4; go to FETCH.
- DONE: absorbing state. All strobes 0, PC and regs frozen, indicator held until reset.
- Latency: 2 cycles per instruction, 3 for LD.
- Strobes are combinational from FSM state and are gated by clk_en.
- Reset asserted mid-instruction aborts the instruction; no partial register write occurs.
- Outputs when idle: data_memory_out_v = 0 and data_memory_a = 0 whenever no data strobe is active.

Optional Feature:
- CPU_MUL_EN defined: op 011000 MUL, rd = low 32 bits of rs1*rs2 (unsigned product), 2-cycle like other ALU ops.
- CPU_MUL_EN undefined: op 011000 is illegal and sets ERROR.

Decomposition:
- Package cpu_pkg:
  - opcode localparams;
  - FSM state enum;
  - indicator codes (IND_HALT = 2'b00, IND_ERROR = 2'b01, IND_RUN = 2'b10);
  - NOP/HALT constant words.
- One sub-module, cpu_alu: combinational op × a × b → result, including the MUL branch under the macro.
- Register file, PC and FSM stay in cpu_core.

Test Plan:
- Basic program: 0x20400005 (ADDI r1,r0,5), 0x20800007 (ADDI r2,r0,7), 0x00C48000 (ADD r3,r1,r2), 0x84C00100 (ST r3,[r0+0x100]), 0xCC000000 (HALT).
  -> data bytes 0x100..0x103 = 0C 00 00 00; indicator = 00 after 10 core cycles.
- 0xFC000000 at address 0 -> indicator = 01 at end of the 2nd cycle; no strobes afterwards.
- Countdown: ADDI r1,r0,3; loop ADDI r1,r1,-1; BNZ r1,-2 words; HALT.
  -> r1 = 0, loop body runs 3 times, then HALT.
- Load: data word 0xDEADBEEF at 0x200; LD r4,[r0+0x200]; ST r4,[r0+0x204]; HALT.
  -> bytes 0x204..0x207 = EF BE AD DE.
- clk_en held 0 for 5 cycles mid-program -> PC, regs and indicator unchanged; strobes 0; program finishes identically afterwards.
- reset pulsed during the MEM state of an LD -> rd not written; PC = 0; indicator = 10; program restarts from PC 0.
